mode_counter: RTL and testbench

//  Parametrised up/down counter: programmable modulus, synchronous load, free-running or one-shot mode.

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_prescaler.sv | 42 ++++
 rtl/mode_counter.sv | 112 +++++++++++
 tb/tb_mode_counter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the mode_counter family: operating modes and one-shot FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_HOLD    = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_prescaler.sv
// Divides the count enable: tick is high on every PRESCALE-th cycle that en is high.
// clr restarts the period; used by mode_counter only when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(PRESCALE) + 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Period counter advances only on enabled cycles.
  always_comb begin
    tick  = en & (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en) begin
      cnt_d = tick ? {CW{1'b0}} : cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Period counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Up/down modulus counter with free-running, one-shot and hold modes and a tc pulse.
// Define COUNTER_PRESCALE_EN to slow the count step to once per PRESCALE enabled cycles.
module mode_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 2**WIDTH-1,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             ld,
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  if (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("mode_counter: MAX_VAL does not fit in WIDTH bits");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mode_counter: PRESCALE must be at least 1");
  end

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  state_e           state_q, state_d;
  logic             tick_s;
  logic             step_s;
  logic             at_term_s;
  logic             is_os_s;
  logic             is_free_s;

`ifdef COUNTER_PRESCALE_EN
  logic prescale_clr_s;
  assign prescale_clr_s = ld | start;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (prescale_clr_s),
    .en   (en),
    .tick (tick_s)
  );
`else
  assign tick_s = 1'b1;
`endif

  // Next-state decode: ld beats start beats step; modes 2 and 3 both freeze.
  always_comb begin
    is_free_s = (mode == MODE_FREE);
    is_os_s   = (mode == MODE_ONESHOT);
    at_term_s = up_dn ? (count_q == MAX_W) : (count_q == ZERO_W);
    step_s    = en & tick_s & (is_free_s | (is_os_s & (state_q == ST_RUN)));
    count_d   = count_q;
    tc_d      = 1'b0;
    if (is_os_s) begin
      state_d = state_q;
    end else begin
      state_d = ST_IDLE;
    end
    if (ld) begin
      count_d = (v > MAX_W) ? MAX_W : v;
    end else if (is_os_s && start) begin
      state_d = ST_RUN;
      count_d = up_dn ? ZERO_W : MAX_W;
    end else if (step_s) begin
      if (!at_term_s) begin
        count_d = up_dn ? count_q + ONE_W : count_q - ONE_W;
      end else if (is_os_s) begin
        // One-shot parks on the terminal value instead of wrapping.
        state_d = ST_DONE;
        count_d = count_q;
        tc_d    = 1'b1;
      end else begin
        count_d = up_dn ? ZERO_W : MAX_W;
        tc_d    = 1'b1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count, terminal pulse and FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= ZERO_W;
      tc_q    <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter (WIDTH=4, MAX_VAL=9, PRESCALE=3) against a range-based model.
module tb_mode_counter;

  localparam int WIDTH    = 4;
  localparam int MAX_VAL  = 9;
  localparam int PRESCALE = 3;

  logic             clk   = 1'b0;
  logic             rst   = 1'b0;
  logic             en    = 1'b0;
  logic             up_dn = 1'b1;
  logic [1:0]       mode  = 2'd0;
  logic             start = 1'b0;
  logic             ld    = 1'b0;
  logic [WIDTH-1:0] v     = 4'd0;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Reference model: value in 0..MAX_VAL, a running flag and an en-cycle counter.
  int m_count = 0, n_count = 0;
  bit m_tc = 1'b0, n_tc = 1'b0;
  bit m_run = 1'b0, n_run = 1'b0;
  int m_pre = 0, n_pre = 0;

  mode_counter #(
    .WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode), .start(start),
    .ld(ld), .v(v), .count(count), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_next();
    bit os, tk, stp;
    int nc;
    os = (mode == 2'd1);
`ifdef COUNTER_PRESCALE_EN
    tk = en && (m_pre == PRESCALE - 1);
    n_pre = (ld || start) ? 0 : (en ? (tk ? 0 : m_pre + 1) : m_pre);
`else
    tk = 1'b1;
    n_pre = m_pre;
`endif
    nc = m_count;
    n_tc = 1'b0;
    n_run = os ? m_run : 1'b0;
    stp = en && tk && (mode == 2'd0 || (os && m_run));
    if (ld) begin
      nc = (int'(v) > MAX_VAL) ? MAX_VAL : int'(v);
    end else if (os && start) begin
      n_run = 1'b1;
      nc = up_dn ? 0 : MAX_VAL;
    end else if (stp) begin
      nc = up_dn ? m_count + 1 : m_count - 1;
      if (nc > MAX_VAL || nc < 0) begin
        n_tc = 1'b1;
        if (os) begin
          n_run = 1'b0;
          nc = m_count;
        end else begin
          nc = (nc + MAX_VAL + 1) % (MAX_VAL + 1);
        end
      end
    end
    if (rst) begin
      nc = 0; n_tc = 1'b0; n_run = 1'b0; n_pre = 0;
    end
    n_count = nc;
  endtask

  task automatic tick_clk();
    model_next();
    @(posedge clk);
    #1;
    m_count = n_count; m_tc = n_tc; m_run = n_run; m_pre = n_pre;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ld = 1'b0; start = 1'b0; mode = 2'd0; up_dn = 1'b1;
    tick_clk();
    rst = 1'b0;
    checks++;
    if (count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d tc=%0b busy=%0b, required 0 0 0", count, tc, busy);
    end
  endtask

  task automatic test_free_up();
`ifndef COUNTER_PRESCALE_EN
    int exp_c [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
`endif
    mode = 2'd0; up_dn = 1'b1; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick_clk();
      checks++;
      if (count !== 4'(m_count) || tc !== m_tc || busy !== m_run) begin
        errors++;
        $display("FAIL free_up_model cyc %0d: count=%0d tc=%0b busy=%0b, required %0d %0b %0b",
                 i, count, tc, busy, m_count, m_tc, m_run);
      end
`ifndef COUNTER_PRESCALE_EN
      checks++;
      if (count !== 4'(exp_c[i]) || tc !== (exp_c[i] == 0)) begin
        errors++;
        $display("FAIL free_up_seq cyc %0d: count=%0d tc=%0b, required %0d %0b",
                 i, count, tc, exp_c[i], exp_c[i] == 0);
      end
`endif
    end
  endtask

  task automatic test_free_down_load();
    bit ld_t  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int v_t   [6] = '{0, 0, 0, 0, 15, 5};
`ifndef COUNTER_PRESCALE_EN
    int exp_c [6] = '{0, 9, 8, 7, 9, 5};
    bit exp_t [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    mode = 2'd0; up_dn = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld = ld_t[i]; v = 4'(v_t[i]);
      tick_clk();
      checks++;
      if (count !== 4'(m_count) || tc !== m_tc) begin
        errors++;
        $display("FAIL down_load_model step %0d: count=%0d tc=%0b, required %0d %0b",
                 i, count, tc, m_count, m_tc);
      end
`ifndef COUNTER_PRESCALE_EN
      checks++;
      if (count !== 4'(exp_c[i]) || tc !== exp_t[i]) begin
        errors++;
        $display("FAIL down_load_seq step %0d: count=%0d tc=%0b, required %0d %0b",
                 i, count, tc, exp_c[i], exp_t[i]);
      end
`endif
    end
    ld = 1'b0;
  endtask

  task automatic test_oneshot();
    int tc_seen = 0;
    int total = 14;
`ifdef COUNTER_PRESCALE_EN
    total = 40;
`endif
    mode = 2'd1; up_dn = 1'b1; en = 1'b1;
    for (int i = 0; i < total; i++) begin
      start = (i == 0 || i == total - 1);
      tick_clk();
      if (tc === 1'b1) tc_seen++;
      checks++;
      if (count !== 4'(m_count) || tc !== m_tc || busy !== m_run) begin
        errors++;
        $display("FAIL oneshot_model cyc %0d: count=%0d tc=%0b busy=%0b, required %0d %0b %0b",
                 i, count, tc, busy, m_count, m_tc, m_run);
      end
`ifndef COUNTER_PRESCALE_EN
      checks++;
      if (count !== 4'((i == 13) ? 0 : ((i < 10) ? i : 9)) ||
          busy !== (i < 10 || i == 13) || tc !== (i == 10)) begin
        errors++;
        $display("FAIL oneshot_seq cyc %0d: count=%0d tc=%0b busy=%0b", i, count, tc, busy);
      end
`endif
    end
    start = 1'b0;
    checks++;
    if (tc_seen != 1) begin
      errors++;
      $display("FAIL oneshot_tc_count: saw %0d tc pulses, required 1", tc_seen);
    end
  endtask

  task automatic test_oneshot_ctrl();
    bit rst_t [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    bit st_t  [12] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    bit ld_t  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int md_t  [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2};
`ifndef COUNTER_PRESCALE_EN
    int exp_c [12] = '{1, 2, 3, 4, 0, 3, 0, 1, 2, 2, 2, 2};
    bit exp_b [12] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
`endif
    up_dn = 1'b1; en = 1'b1; v = 4'd3;
    for (int i = 0; i < 12; i++) begin
      rst = rst_t[i]; start = st_t[i]; ld = ld_t[i]; mode = 2'(md_t[i]);
      tick_clk();
      checks++;
      if (count !== 4'(m_count) || tc !== m_tc || busy !== m_run) begin
        errors++;
        $display("FAIL ctrl_model step %0d: count=%0d tc=%0b busy=%0b, required %0d %0b %0b",
                 i, count, tc, busy, m_count, m_tc, m_run);
      end
`ifndef COUNTER_PRESCALE_EN
      checks++;
      if (count !== 4'(exp_c[i]) || busy !== exp_b[i] || tc !== 1'b0) begin
        errors++;
        $display("FAIL ctrl_seq step %0d: count=%0d busy=%0b tc=%0b, required %0d %0b 0",
                 i, count, busy, tc, exp_c[i], exp_b[i]);
      end
`endif
    end
    rst = 1'b0; start = 1'b0; ld = 1'b0;
  endtask

`ifdef COUNTER_PRESCALE_EN
  task automatic test_prescale();
    bit en_t  [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    int exp_c [11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
    rst = 1'b1;
    tick_clk();
    rst = 1'b0; mode = 2'd0; up_dn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      en = en_t[i];
      tick_clk();
      checks++;
      if (count !== 4'(exp_c[i]) || count !== 4'(m_count)) begin
        errors++;
        $display("FAIL prescale step %0d: count=%0d, required %0d (model %0d)",
                 i, count, exp_c[i], m_count);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      rst   = ($urandom_range(0, 511) == 0);
      ld    = ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      v = 4'($urandom);
      tick_clk();
      checks++;
      if (count !== 4'(m_count) || tc !== m_tc || busy !== m_run) begin
        errors++;
        $display("FAIL random cyc %0d: count=%0d tc=%0b busy=%0b, required %0d %0b %0b",
                 i, count, tc, busy, m_count, m_tc, m_run);
      end
      checks++;
      if (count > 4'(MAX_VAL)) begin
        errors++;
        $display("FAIL random_range cyc %0d: count=%0d, required <= %0d", i, count, MAX_VAL);
      end
    end
    rst = 1'b0; ld = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_up();
    test_free_down_load();
    test_oneshot();
    test_oneshot_ctrl();
`ifdef COUNTER_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
